scc_bus_master: RTL and testbench

- Host-side initiator that drives the SCC register/wave-RAM slave port (wrreq/rdreq/wr_active/rd_active/a/d/q).
- Accepts a stream of read/write commands through a small command FIFO.
- Serialises the commands into slave bus cycles with programmable active length and inter-cycle gap, and returns read data on a response port.
- Used in test harnesses and in register-replay players (VGM-style) that feed scc_core directly, with no Z80 bus.

---
 rtl/scc_bus_master.sv | 187 ++++++++++++++++++
 tb/tb_scc_bus_master.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_bus_master.sv
// ---------------------------------------------------------------------------
// scc_bus_master
//
// Host-side initiator for the SCC register / wave-RAM slave port. Commands
// are queued in a small FIFO and replayed one at a time as slave bus cycles.
// Each bus cycle has a programmable active length and is followed by a
// programmable idle gap. Read results come back on the response port.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (transfer when both high at an edge)
//   cmd_write           1 = write, 0 = read
//   cmd_address[14:0]   target address
//   cmd_wrdata[7:0]     write data (ignored for reads)
//   rsp_valid           one-clock pulse when rsp_data carries a new read result
//   rsp_data[7:0]       last read result, held until the next read completes
//   busy                FIFO non-empty or a transaction in progress
//   wrreq/rdreq         request pulses to the slave (first active clock only)
//   wr_active/rd_active cycle-active strobes to the slave
//   a[14:0], d[7:0]     bus address / write data, held between transactions
//   q[7:0]              slave read data
// ---------------------------------------------------------------------------
module scc_bus_master #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int WR_CYCLES       = 3,
    parameter int RD_CYCLES       = 3,
    parameter int GAP_CYCLES      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [14:0] cmd_address,
    input  logic [7:0]  cmd_wrdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        wrreq,
    output logic        rdreq,
    output logic        wr_active,
    output logic        rd_active,
    output logic [14:0] a,
    output logic [7:0]  d,
    input  logic [7:0]  q
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [3:0]       WR_LOAD    = 4'(WR_CYCLES - 1);
    localparam logic [3:0]       RD_LOAD    = 4'(RD_CYCLES - 1);
    localparam logic [3:0]       GAP_LOAD   = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Entry layout: {write, address[14:0], data[7:0]}
    logic [23:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [23:0]      head;

    state_t           state;
    logic [3:0]       act_cnt;
    logic [3:0]       gap_cnt;

    // cmd_ready is the registered "not full" flag, so a pop on the same edge
    // as a full FIFO never makes room for that edge's push.
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count == '0);
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_address, cmd_wrdata};
        end
    end

    // Pointers and occupancy. cmd_ready is recomputed from the next count so
    // it always matches the occupancy the following edge will see.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            cmd_ready <= (count_next != FULL_COUNT);
        end
    end

    // Bus sequencer. The active strobe that is currently high tells ACTIVE
    // whether the transaction is a read, so no separate type flag is kept.
    // busy reflects the state being entered at this edge: it drops exactly on
    // the GAP->IDLE edge when nothing is queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            act_cnt   <= '0;
            gap_cnt   <= '0;
            wrreq     <= 1'b0;
            rdreq     <= 1'b0;
            wr_active <= 1'b0;
            rd_active <= 1'b0;
            a         <= '0;
            d         <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            wrreq     <= 1'b0;
            rdreq     <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= !fifo_empty || (state == ACTIVE) ||
                         ((state == GAP) && (gap_cnt != '0));

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        a <= head[22:8];
                        if (head[23]) begin
                            d         <= head[7:0];
                            wrreq     <= 1'b1;
                            wr_active <= 1'b1;
                            act_cnt   <= WR_LOAD;
                        end else begin
                            rdreq     <= 1'b1;
                            rd_active <= 1'b1;
                            act_cnt   <= RD_LOAD;
                        end
                        state <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (act_cnt == '0) begin
                        // q is taken at the end of the last rd_active clock.
                        if (rd_active) begin
                            rsp_data  <= q;
                            rsp_valid <= 1'b1;
                        end
                        wr_active <= 1'b0;
                        rd_active <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                        state     <= GAP;
                    end else begin
                        act_cnt <= act_cnt - 4'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scc_bus_master.sv
// ---------------------------------------------------------------------------
// tb_scc_bus_master
//
// Directed bench for scc_bus_master. Two instances share clock and reset:
// dut uses the default parameters, dut_r1 uses RD_CYCLES = 1 for the short
// read followed by a write. Cycle k is the clock period after edge k, and
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_scc_bus_master;

    logic        clk;
    logic        reset;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [14:0] cmd_address;
    logic [7:0]  cmd_wrdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        wrreq;
    logic        rdreq;
    logic        wr_active;
    logic        rd_active;
    logic [14:0] a;
    logic [7:0]  d;
    logic [7:0]  q;

    logic        q_manual_en;
    logic [7:0]  q_manual;

    logic        r1_cmd_valid;
    logic        r1_cmd_ready;
    logic        r1_cmd_write;
    logic [14:0] r1_cmd_address;
    logic [7:0]  r1_cmd_wrdata;
    logic        r1_rsp_valid;
    logic [7:0]  r1_rsp_data;
    logic        r1_busy;
    logic        r1_wrreq;
    logic        r1_rdreq;
    logic        r1_wr_active;
    logic        r1_rd_active;
    logic [14:0] r1_a;
    logic [7:0]  r1_d;
    logic [7:0]  r1_q;

    int total;
    int bad;

    // Slave model: either a forced value or a simple function of the address.
    assign q = q_manual_en ? q_manual : (a[7:0] ^ 8'h5A);

    scc_bus_master dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_address (cmd_address),
        .cmd_wrdata  (cmd_wrdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .wrreq       (wrreq),
        .rdreq       (rdreq),
        .wr_active   (wr_active),
        .rd_active   (rd_active),
        .a           (a),
        .d           (d),
        .q           (q)
    );

    scc_bus_master #(
        .FIFO_DEPTH_LOG2 (2),
        .WR_CYCLES       (3),
        .RD_CYCLES       (1),
        .GAP_CYCLES      (1)
    ) dut_r1 (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (r1_cmd_valid),
        .cmd_ready   (r1_cmd_ready),
        .cmd_write   (r1_cmd_write),
        .cmd_address (r1_cmd_address),
        .cmd_wrdata  (r1_cmd_wrdata),
        .rsp_valid   (r1_rsp_valid),
        .rsp_data    (r1_rsp_data),
        .busy        (r1_busy),
        .wrreq       (r1_wrreq),
        .rdreq       (r1_rdreq),
        .wr_active   (r1_wr_active),
        .rd_active   (r1_rd_active),
        .a           (r1_a),
        .d           (r1_d),
        .q           (r1_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({wrreq, rdreq, wr_active, rd_active, rsp_valid, busy} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_strobes got=%b want=%b",
                     {wrreq, rdreq, wr_active, rd_active, rsp_valid, busy}, 6'b0);
        end
        total++;
        if ({a, d, rsp_data} !== 31'h0) begin
            bad++;
            $display("[TB] FAIL reset_bus got=%h want=%h", {a, d, rsp_data}, 31'h0);
        end
        total++;
        if ({r1_wrreq, r1_rdreq, r1_wr_active, r1_rd_active, r1_rsp_valid, r1_busy} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_r1_strobes got=%b want=%b",
                     {r1_wrreq, r1_rdreq, r1_wr_active, r1_rd_active, r1_rsp_valid, r1_busy}, 6'b0);
        end
        #4 reset = 1'b0;
        tick();
        total++;
        if ({cmd_ready, busy} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL reset_release_ready_busy got=%b want=%b", {cmd_ready, busy}, 2'b10);
        end
    endtask

    // Single write at 0x9800 (15-bit port sees 0x1800), accepted at edge 0.
    task automatic test_single_write();
        logic [4:0] got;
        logic [4:0] exp;
        cmd_write   = 1'b1;
        cmd_address = 15'h1800;
        cmd_wrdata  = 8'h5A;
        cmd_valid   = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL write_ready got=%b want=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_busy_c0 got=%b want=0", busy);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp = {(c == 1), (c >= 1 && c <= 3), 1'b0, 1'b0, (c <= 4)};
            got = {wrreq, wr_active, rdreq, rd_active, busy};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL write_strobes cycle=%0d got=%b want=%b", c, got, exp);
            end
            total++;
            if ({a, d} !== {15'h1800, 8'h5A}) begin
                bad++;
                $display("[TB] FAIL write_bus cycle=%0d got=%h/%h want=1800/5a", c, a, d);
            end
        end
    endtask

    // Single read at 0x9880. q changes during the read so an early sample
    // would pick up the wrong value; only the last rd_active clock counts.
    task automatic test_single_read();
        logic [4:0] got;
        logic [4:0] exp;
        q_manual_en = 1'b1;
        q_manual    = 8'h11;
        cmd_write   = 1'b0;
        cmd_address = 15'h1880;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp = {(c == 1), (c >= 1 && c <= 3), 1'b0, 1'b0, (c == 4)};
            got = {rdreq, rd_active, wrreq, wr_active, rsp_valid};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL read_strobes cycle=%0d got=%b want=%b", c, got, exp);
            end
            total++;
            if (a !== 15'h1880) begin
                bad++;
                $display("[TB] FAIL read_addr cycle=%0d got=%h want=1880", c, a);
            end
            if (c >= 4) begin
                total++;
                if (rsp_data !== 8'hC3) begin
                    bad++;
                    $display("[TB] FAIL read_data cycle=%0d got=%h want=c3", c, rsp_data);
                end
            end
            if (c == 3) q_manual = 8'hC3;
            if (c == 4) q_manual = 8'h3C;
        end
        q_manual_en = 1'b0;
    endtask

    // One write gets the FSM going, then five more are offered continuously.
    task automatic test_back_to_back();
        logic [14:0] b_addr [6];
        logic [7:0]  b_data [6];
        int          acc_edge [6];
        int          idx;
        logic        was_ready;
        logic [7:0]  exp_ready;
        logic        exp_req;
        logic        exp_act;
        exp_ready = 8'b0100_1111;
        for (int i = 0; i < 6; i++) begin
            b_addr[i]   = 15'h1800 + 15'(i);
            b_data[i]   = 8'h10 + 8'(i);
            acc_edge[i] = -1;
        end
        idx         = 0;
        cmd_write   = 1'b1;
        cmd_address = b_addr[0];
        cmd_wrdata  = b_data[0];
        cmd_valid   = 1'b1;
        for (int c = 0; c <= 31; c++) begin
            was_ready = cmd_ready;
            tick();
            if (cmd_valid && was_ready) begin
                acc_edge[idx] = c;
                idx++;
            end
            if (idx < 6) begin
                cmd_address = b_addr[idx];
                cmd_wrdata  = b_data[idx];
            end else begin
                cmd_valid = 1'b0;
            end
            if (c <= 7) begin
                total++;
                if (cmd_ready !== exp_ready[c]) begin
                    bad++;
                    $display("[TB] FAIL b2b_ready cycle=%0d got=%b want=%b", c, cmd_ready, exp_ready[c]);
                end
            end
            exp_req = (c >= 1 && c <= 26 && (c - 1) % 5 == 0);
            exp_act = (c >= 1 && c <= 28 && (c - 1) % 5 <= 2);
            total++;
            if ({wrreq, wr_active, rd_active} !== {exp_req, exp_act, 1'b0}) begin
                bad++;
                $display("[TB] FAIL b2b_strobes cycle=%0d got=%b want=%b",
                         c, {wrreq, wr_active, rd_active}, {exp_req, exp_act, 1'b0});
            end
            if (exp_req) begin
                total++;
                if ({a, d} !== {b_addr[(c - 1) / 5], b_data[(c - 1) / 5]}) begin
                    bad++;
                    $display("[TB] FAIL b2b_order cycle=%0d got=%h/%h want=%h/%h",
                             c, a, d, b_addr[(c - 1) / 5], b_data[(c - 1) / 5]);
                end
            end
            total++;
            if (busy !== (c >= 1 && c <= 29)) begin
                bad++;
                $display("[TB] FAIL b2b_busy cycle=%0d got=%b want=%b", c, busy, (c >= 1 && c <= 29));
            end
        end
        total++;
        if (acc_edge[4] != 4 || acc_edge[5] != 7) begin
            bad++;
            $display("[TB] FAIL b2b_accept_edges got=%0d,%0d want=4,7", acc_edge[4], acc_edge[5]);
        end
    endtask

    // RD_CYCLES = 1 instance: read then write offered on consecutive edges.
    task automatic test_read_then_write();
        logic [4:0] got;
        logic [4:0] exp;
        r1_cmd_write   = 1'b0;
        r1_cmd_address = 15'h0012;
        r1_cmd_valid   = 1'b1;
        tick();
        r1_cmd_write   = 1'b1;
        r1_cmd_address = 15'h0034;
        r1_cmd_wrdata  = 8'h99;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) r1_cmd_valid = 1'b0;
            exp = {(c == 1), (c == 1), (c == 2), (c == 4), (c >= 4 && c <= 6)};
            got = {r1_rdreq, r1_rd_active, r1_rsp_valid, r1_wrreq, r1_wr_active};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL rd1_strobes cycle=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 2) begin
                total++;
                if (r1_rsp_data !== 8'h77) begin
                    bad++;
                    $display("[TB] FAIL rd1_data got=%h want=77", r1_rsp_data);
                end
            end
            if (c == 4) begin
                total++;
                if ({r1_a, r1_d} !== {15'h0034, 8'h99}) begin
                    bad++;
                    $display("[TB] FAIL rd1_write_bus got=%h/%h want=0034/99", r1_a, r1_d);
                end
            end
        end
    endtask

    // Reset lands in the second wr_active clock with a read and a write queued.
    task automatic test_reset_mid_write();
        logic [5:0] got;
        cmd_write   = 1'b1;
        cmd_address = 15'h0100;
        cmd_wrdata  = 8'hAB;
        cmd_valid   = 1'b1;
        tick();
        cmd_write   = 1'b0;
        cmd_address = 15'h0101;
        tick();
        cmd_write   = 1'b1;
        cmd_address = 15'h0102;
        cmd_wrdata  = 8'hCD;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (wr_active !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid_pre got=%b want=1", wr_active);
        end
        #1 reset = 1'b1;
        #1;
        got = {wrreq, rdreq, wr_active, rd_active, rsp_valid, busy};
        total++;
        if (got !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_async got=%b want=%b", got, 6'b0);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({cmd_ready, busy, a} !== {1'b1, 1'b0, 15'h0}) begin
            bad++;
            $display("[TB] FAIL rst_mid_release got=%b/%b/%h want=1/0/0000", cmd_ready, busy, a);
        end
        for (int c = 0; c < 15; c++) begin
            tick();
            got = {wrreq, rdreq, wr_active, rd_active, rsp_valid, busy};
            total++;
            if (got !== 6'b0) begin
                bad++;
                $display("[TB] FAIL rst_mid_quiet cycle=%0d got=%b want=%b", c, got, 6'b0);
            end
        end
    endtask

    // Occupancy 2 with a push and a pop on edge 6, then pushes until full.
    task automatic test_same_edge();
        logic [14:0] s_addr [7];
        int          acc_edge [7];
        int          exp_edge [7];
        int          idx;
        int          bus_idx;
        logic        was_ready;
        exp_edge = '{0, 1, 2, 6, 7, 8, 12};
        for (int i = 0; i < 7; i++) begin
            s_addr[i]   = 15'h0200 + 15'(i);
            acc_edge[i] = -1;
        end
        idx         = 0;
        bus_idx     = 0;
        cmd_write   = 1'b1;
        cmd_address = s_addr[0];
        cmd_wrdata  = 8'h30;
        cmd_valid   = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            was_ready = cmd_ready;
            tick();
            if (cmd_valid && was_ready) begin
                acc_edge[idx] = c;
                idx++;
            end
            if (idx < 7 && (c + 1 <= 2 || c + 1 >= 6)) begin
                cmd_valid   = 1'b1;
                cmd_address = s_addr[idx];
                cmd_wrdata  = 8'h30 + 8'(idx);
            end else begin
                cmd_valid = 1'b0;
            end
            if (c >= 6 && c <= 11) begin
                total++;
                if (cmd_ready !== (c <= 7 || c == 11)) begin
                    bad++;
                    $display("[TB] FAIL same_edge_ready cycle=%0d got=%b want=%b",
                             c, cmd_ready, (c <= 7 || c == 11));
                end
            end
            if (wrreq) begin
                if (bus_idx < 7) begin
                    total++;
                    if (a !== s_addr[bus_idx]) begin
                        bad++;
                        $display("[TB] FAIL same_edge_order idx=%0d got=%h want=%h", bus_idx, a, s_addr[bus_idx]);
                    end
                end
                bus_idx++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (acc_edge[i] != exp_edge[i]) begin
                bad++;
                $display("[TB] FAIL same_edge_accept idx=%0d got=%0d want=%0d", i, acc_edge[i], exp_edge[i]);
            end
        end
        total++;
        if (bus_idx != 7) begin
            bad++;
            $display("[TB] FAIL same_edge_count got=%0d want=7", bus_idx);
        end
    endtask

    // 32 mixed commands streamed through the FIFO, wrapping the pointers
    // many times; bus order and read responses are checked against the list.
    task automatic test_wrap();
        logic        w_list [32];
        logic [14:0] a_list [32];
        logic [7:0]  d_list [32];
        int          idx;
        int          bus_idx;
        int          rsp_cnt;
        logic        was_ready;
        logic        rsp_pending;
        logic [7:0]  rsp_exp;
        logic [23:0] got;
        logic [23:0] exp;
        for (int i = 0; i < 32; i++) begin
            w_list[i] = (i % 3 != 1);
            a_list[i] = 15'h2000 + 15'(i * 37);
            d_list[i] = 8'(i * 13 + 7);
        end
        idx         = 0;
        bus_idx     = 0;
        rsp_cnt     = 0;
        rsp_pending = 1'b0;
        rsp_exp     = 8'h00;
        cmd_write   = w_list[0];
        cmd_address = a_list[0];
        cmd_wrdata  = d_list[0];
        cmd_valid   = 1'b1;
        for (int c = 0; c < 200; c++) begin
            was_ready = cmd_ready;
            tick();
            if (cmd_valid && was_ready) idx++;
            if (idx < 32) begin
                cmd_write   = w_list[idx];
                cmd_address = a_list[idx];
                cmd_wrdata  = d_list[idx];
            end else begin
                cmd_valid = 1'b0;
            end
            if (wrreq || rdreq) begin
                if (bus_idx < 32) begin
                    got = {wrreq, a, (wrreq ? d : 8'h00)};
                    exp = {w_list[bus_idx], a_list[bus_idx], (w_list[bus_idx] ? d_list[bus_idx] : 8'h00)};
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("[TB] FAIL wrap_bus idx=%0d got=%h want=%h", bus_idx, got, exp);
                    end
                    if (rdreq) begin
                        rsp_pending = 1'b1;
                        rsp_exp     = a_list[bus_idx][7:0] ^ 8'h5A;
                    end
                end
                bus_idx++;
            end
            if (rsp_valid) begin
                total++;
                if (!rsp_pending || rsp_data !== rsp_exp) begin
                    bad++;
                    $display("[TB] FAIL wrap_rsp got=%h pending=%b want=%h", rsp_data, rsp_pending, rsp_exp);
                end
                rsp_pending = 1'b0;
                rsp_cnt++;
            end
            total++;
            if ((wr_active && rd_active) || (wrreq && !wr_active) || (rdreq && !rd_active)) begin
                bad++;
                $display("[TB] FAIL wrap_strobe_rules cycle=%0d got=%b want=no overlap",
                         c, {wrreq, wr_active, rdreq, rd_active});
            end
        end
        total++;
        if (idx != 32 || bus_idx != 32 || rsp_cnt != 11) begin
            bad++;
            $display("[TB] FAIL wrap_counts got=%0d/%0d/%0d want=32/32/11", idx, bus_idx, rsp_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_write      = 1'b0;
        cmd_address    = 15'h0;
        cmd_wrdata     = 8'h0;
        q_manual_en    = 1'b0;
        q_manual       = 8'h00;
        r1_cmd_valid   = 1'b0;
        r1_cmd_write   = 1'b0;
        r1_cmd_address = 15'h0;
        r1_cmd_wrdata  = 8'h0;
        r1_q           = 8'h77;

        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_read_then_write();
        test_reset_mid_write();
        test_same_edge();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
